dec_lut_sched: RTL and testbench

DEC_LUT_SCHED -- requirements
Module: dec_lut_sched

---
 rtl/dec_lut_pkg.sv | 16 +
 rtl/dec_lut_rr_arb.sv | 37 +++
 rtl/dec_lut_sched.sv | 159 +++++++++++++++
 tb/tb_dec_lut_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dec_lut_pkg.sv
// Shared definitions for the DEC_LUT request scheduler.
// Provides the FSM state encoding and the WAIT timeout counter width.
package dec_lut_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   // WAIT-cycle counter width; covers TIMEOUT up to 1023
   localparam int unsigned CNT_W = 10;

endpackage : dec_lut_pkg

// File: rtl/dec_lut_rr_arb.sv
// Combinational round-robin arbiter.
// Ports:
//   req     - request vector, one bit per requester
//   last    - index of the previous winner; search starts at last+1
//   grant_c - one-hot grant (zero when no request)
//   idx_c   - index of the granted requester
//   valid_c - high when any requester is granted
module dec_lut_rr_arb #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] grant_c,
   output logic [IDX_W-1:0]   idx_c,
   output logic               valid_c
);

   logic [IDX_W-1:0] cand;

   // NUM_REQ is a power of two, so the index wraps naturally modulo NUM_REQ
   always_comb begin
      grant_c = '0;
      idx_c   = '0;
      valid_c = 1'b0;
      cand    = '0;
      for (int unsigned o = 1; o <= NUM_REQ; o++) begin
         cand = last + IDX_W'(o);
         if (!valid_c && req[cand]) begin
            valid_c       = 1'b1;
            grant_c[cand] = 1'b1;
            idx_c         = cand;
         end
      end
   end

endmodule : dec_lut_rr_arb

// File: rtl/dec_lut_sched.sv
// Schedules NUM_REQ requesters onto one shared DEC_LUT decoder.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   req_valid/req_ready  - per-requester request and registered accept strobe
//   req_w                - packed operands, requester i at [i*W_BITS +: W_BITS]
//   rsp_valid/rsp_ready  - response handshake
//   rsp_id/rsp_n/rsp_err - requester index, decoder result, timeout flag
//   dec_w                - operand driven to the decoder
//   dec_found/dec_n      - decoder completion flag and result
//   busy                 - high whenever the FSM is not idle
module dec_lut_sched
   import dec_lut_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned W_BITS  = 44,
   parameter int unsigned N_BITS  = 29,
   parameter int unsigned TIMEOUT = 1023,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*W_BITS-1:0] req_w,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [IDX_W-1:0]          rsp_id,
   output logic [N_BITS-1:0]         rsp_n,
   output logic                      rsp_err,
   output logic [W_BITS-1:0]         dec_w,
   input  logic                      dec_found,
   input  logic [N_BITS-1:0]         dec_n,
   output logic                      busy
);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [IDX_W-1:0]     id_q, id_d;
   logic [W_BITS-1:0]    dec_w_q, dec_w_d;
   logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [N_BITS-1:0]    rsp_n_q, rsp_n_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 busy_q, busy_d;

   logic [NUM_REQ-1:0]   arb_grant;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_valid;
   logic [W_BITS-1:0]    w_arr [NUM_REQ];

   // Unpack the flat operand bus so the winner can be selected by index
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_arr[gi] = req_w[gi*W_BITS +: W_BITS];
   end

   dec_lut_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req     (req_valid),
      .last    (last_q),
      .grant_c (arb_grant),
      .idx_c   (arb_idx),
      .valid_c (arb_valid)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      id_d        = id_q;
      dec_w_d     = dec_w_q;
      req_ready_d = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_n_d     = rsp_n_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               state_d     = ST_SETTLE;
               req_ready_d = arb_grant;
               dec_w_d     = w_arr[arb_idx];
               id_d        = arb_idx;
               last_d      = arb_idx;
            end
         end
         ST_SETTLE: begin
            // dec_found may still reflect the previous operand; ignore it here
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            // A found result wins over a timeout landing in the same cycle
            if (dec_found) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_n_d     = dec_n;
               rsp_err_d   = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_n_d     = '0;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         last_q      <= IDX_W'(NUM_REQ - 1);
         id_q        <= '0;
         dec_w_q     <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_n_q     <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         id_q        <= id_d;
         dec_w_q     <= dec_w_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_n_q     <= rsp_n_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = id_q;
   assign rsp_n     = rsp_n_q;
   assign rsp_err   = rsp_err_q;
   assign dec_w     = dec_w_q;
   assign busy      = busy_q;

endmodule : dec_lut_sched

// File: tb/tb_dec_lut_sched.sv
// Self-checking bench for dec_lut_sched: directed table, reset corner case,
// then randomized transactions against a transaction-level model.
module tb_dec_lut_sched;

   localparam int NUM_REQ = 4;
   localparam int W_BITS  = 44;
   localparam int N_BITS  = 29;
   localparam int TIMEOUT = 1023;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*W_BITS-1:0] req_w;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [1:0]                rsp_id;
   logic [N_BITS-1:0]         rsp_n;
   logic                      rsp_err;
   logic [W_BITS-1:0]         dec_w;
   logic                      dec_found;
   logic [N_BITS-1:0]         dec_n;
   logic                      busy;

   int checks = 0;
   int errors = 0;
   int last_m = NUM_REQ - 1;

   dec_lut_sched #(
      .NUM_REQ (NUM_REQ),
      .W_BITS  (W_BITS),
      .N_BITS  (N_BITS),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_w     (req_w),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_n     (rsp_n),
      .rsp_err   (rsp_err),
      .dec_w     (dec_w),
      .dec_found (dec_found),
      .dec_n     (dec_n),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]        mask;
      int                k;       // WAIT index where dec_found rises, -1 = never
      logic [N_BITS-1:0] n;
      int                stall;   // cycles rsp_ready stays low in RESP
      bit                stale;   // dec_found high during SETTLE
      int                exp_id;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Round-robin rule: first requesting index after the previous winner
   function automatic int model_grant(input logic [3:0] m, input int last);
      for (int o = 1; o <= NUM_REQ; o++) begin
         int c;
         c = (last + o) % NUM_REQ;
         if (m[c]) return c;
      end
      return -1;
   endfunction

   // One full transaction; called at a negedge with the DUT idle
   task automatic do_txn(input logic [3:0] mask, input int k, input logic [N_BITS-1:0] n,
                         input int stall, input bit stale, input int exp_id, input string tag);
      logic [W_BITS-1:0] ws [NUM_REQ];
      logic [3:0]        oh;
      int                lat;
      int                exp_lat;
      bit                seen;
      logic [N_BITS-1:0] exp_n;
      for (int i = 0; i < NUM_REQ; i++) begin
         ws[i] = W_BITS'({$urandom(), $urandom()});
         req_w[i*W_BITS +: W_BITS] = ws[i];
      end
      req_valid = mask;
      @(negedge clk);
      if (exp_id < 0) begin
         chk({tag, ".nogrant_ready"}, 64'(req_ready), 64'(0));
         chk({tag, ".nogrant_busy"}, 64'(busy), 64'(0));
         req_valid = '0;
         return;
      end
      oh = '0;
      oh[exp_id] = 1'b1;
      chk({tag, ".grant"}, 64'(req_ready), 64'(oh));
      chk({tag, ".dec_w"}, 64'(dec_w), 64'(ws[exp_id]));
      chk({tag, ".busy_settle"}, 64'(busy), 64'(1));
      dec_found = stale;
      dec_n     = N_BITS'($urandom());
      seen = 1'b0;
      lat  = -1;
      for (int cyc = 1; cyc <= TIMEOUT + 8; cyc++) begin
         @(negedge clk);
         if (cyc == 1) chk({tag, ".ready_pulse"}, 64'(req_ready), 64'(0));
         if (rsp_valid) begin
            lat  = cyc;
            seen = 1'b1;
            break;
         end
         dec_found = (cyc - 1 == k);
         dec_n     = (cyc - 1 == k) ? n : N_BITS'($urandom());
      end
      dec_found = 1'b0;
      exp_lat = (k < 0) ? TIMEOUT + 1 : k + 2;
      exp_n   = (k < 0) ? '0 : n;
      chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      if (!seen) begin
         req_valid = '0;
         return;
      end
      for (int s = 0; s <= stall; s++) begin
         chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(1));
         chk({tag, ".rsp_id"}, 64'(rsp_id), 64'(exp_id));
         chk({tag, ".rsp_n"}, 64'(rsp_n), 64'(exp_n));
         chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(k < 0));
         chk({tag, ".resp_busy"}, 64'(busy), 64'(1));
         chk({tag, ".resp_noready"}, 64'(req_ready), 64'(0));
         if (s == stall) rsp_ready = 1'b1;
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      chk({tag, ".done_valid"}, 64'(rsp_valid), 64'(0));
      chk({tag, ".done_busy"}, 64'(busy), 64'(0));
      chk({tag, ".done_nogrant"}, 64'(req_ready), 64'(0));
      last_m    = exp_id;
      req_valid = '0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".req_ready"}, 64'(req_ready), 64'(0));
      chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(0));
      chk({tag, ".rsp_id"}, 64'(rsp_id), 64'(0));
      chk({tag, ".rsp_n"}, 64'(rsp_n), 64'(0));
      chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(0));
      chk({tag, ".dec_w"}, 64'(dec_w), 64'(0));
      chk({tag, ".busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      vec_t vecs [12];
      int   n_to;

      //            mask    k   n              stall stale id
      vecs[0]  = '{4'b1111, 0,  29'h0000123,  0,    0,    0};
      vecs[1]  = '{4'b1111, 1,  29'h1abcdef,  0,    0,    1};
      vecs[2]  = '{4'b1111, 2,  29'h0000001,  1,    1,    2};
      vecs[3]  = '{4'b1111, 3,  29'h1555555,  0,    0,    3};
      vecs[4]  = '{4'b1111, 0,  29'h0aaaaaa,  0,    0,    0};
      vecs[5]  = '{4'b0001, 5,  29'd268435455, 0,   0,    0};
      vecs[6]  = '{4'b0010, 0,  29'h1234567,  10,   0,    1};
      vecs[7]  = '{4'b0000, 0,  29'h0,        0,    0,   -1};
      vecs[8]  = '{4'b1100, 3,  29'h0f0f0f0,  0,    1,    2};
      vecs[9]  = '{4'b1001, 7,  29'h1ffffff,  2,    0,    3};
      vecs[10] = '{4'b0100, -1, 29'h1111111,  0,    1,    2};
      vecs[11] = '{4'b0101, 4,  29'h0333333,  0,    0,    0};

      rst = 1'b1;
      req_valid = '0;
      req_w = '0;
      rsp_ready = 1'b0;
      dec_found = 1'b0;
      dec_n = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++)
         do_txn(vecs[i].mask, vecs[i].k, vecs[i].n, vecs[i].stall, vecs[i].stale,
                vecs[i].exp_id, $sformatf("vec%0d", i));

      // Reset in the middle of WAIT: outputs clear at once, no response follows
      req_valid = 4'b0010;
      @(negedge clk);
      chk("midrst.grant", 64'(req_ready), 64'(4'b0010));
      req_valid = '0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      dec_found = 1'b1;
      dec_n = 29'h1fffffff;
      @(negedge clk);
      chk("midrst.no_rsp", 64'(rsp_valid), 64'(0));
      chk("midrst.idle", 64'(busy), 64'(0));
      dec_found = 1'b0;
      last_m = NUM_REQ - 1;
      do_txn(4'b1111, 1, 29'h0badbad, 0, 0, 0, "postrst");

      // Randomized transactions against the round-robin model
      n_to = 0;
      for (int t = 0; t < 40; t++) begin
         logic [3:0] m;
         int         k;
         m = 4'($urandom_range(0, 15));
         k = int'($urandom_range(0, 20));
         if ($urandom_range(0, 9) == 0 && n_to < 3) begin
            k = -1;
            n_to++;
         end
         do_txn(m, k, N_BITS'($urandom()), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), model_grant(m, last_m), $sformatf("rnd%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dec_lut_sched
